// File: rtl/fm_tuner.sv
// FM transmitter front-panel controller: debounced buttons step the carrier and toggle mute,
// every retune is sequenced as ramp-down / retune / settle / ramp-up on the PCM gain.
module fm_tuner #(
    parameter int unsigned F_MIN           = 87500000,
    parameter int unsigned F_MAX           = 108000000,
    parameter int unsigned F_STEP          = 100000,
    parameter int unsigned F_DEFAULT       = 108000000,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000,
    parameter int unsigned RAMP_DIV        = 98,
    parameter int unsigned SETTLE_CYCLES   = 25000
) (
    input  logic               clk_25m,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_center,
    input  logic signed [15:0] pcm_in,
    output logic signed [15:0] pcm_out,
    output logic        [31:0] cw_freq,
    output logic               tuning,
    output logic               muted
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam int unsigned DIV_W   = $clog2(RAMP_DIV + 1);
    localparam int unsigned SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned GAIN_W  = 9;

    typedef enum logic [2:0] {
        S_IDLE, S_RAMP_DOWN, S_RETUNE, S_SETTLE, S_RAMP_UP
    } state_e;

    typedef enum logic [1:0] {
        PEND_NONE, PEND_UP, PEND_DOWN
    } pend_e;

    // Button index: 0 = up, 1 = down, 2 = center
    logic [2:0]      sync1_q, sync2_q, stable_q, stable_prev_q;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [RPT_W-1:0] rpt_cnt_q [2];
    logic [1:0]      rpt_q;
    logic [2:0]      press;
    logic [1:0]      rpt_fire, step_evt;
    logic            both_held;

    state_e              state_q, state_d;
    pend_e               pend_q, pend_d;
    logic [GAIN_W-1:0]   gain_q, gain_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [31:0]         freq_q, freq_d;
    logic                muted_q, muted_d;
    logic                tuning_q, tuning_d;
    logic signed [15:0]  pcm_q;
    logic signed [25:0]  prod;

    assign both_held = stable_q[0] & stable_q[1];
    assign press     = stable_q & ~stable_prev_q;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rpt_fire[i] = stable_q[i] && !both_held &&
                (rpt_cnt_q[i] == (rpt_q[i] ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY)));
            step_evt[i] = !both_held && (press[i] || rpt_fire[i]);
        end
    end

    // Synchronise, debounce and time autorepeat for each button
    always_ff @(posedge clk_25m or posedge reset) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            rpt_q         <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            for (int i = 0; i < 2; i++) rpt_cnt_q[i] <= '0;
        end else begin
            sync1_q       <= {btn_center, btn_down, btn_up};
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!stable_q[i] || both_held) begin
                    rpt_cnt_q[i] <= '0;
                    rpt_q[i]     <= 1'b0;
                end else if (rpt_fire[i]) begin
                    rpt_cnt_q[i] <= RPT_W'(1);
                    rpt_q[i]     <= 1'b1;
                end else begin
                    rpt_cnt_q[i] <= rpt_cnt_q[i] + RPT_W'(1);
                end
            end
        end
    end

    // Retune sequencer: gain ramps bracket every carrier change
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        gain_d   = gain_q;
        div_d    = div_q;
        settle_d = settle_q;
        freq_d   = freq_q;
        muted_d  = muted_q ^ press[2];
        case (state_q)
            S_IDLE: begin
                div_d    = '0;
                settle_d = '0;
                if (pend_q != PEND_NONE)                         state_d = S_RAMP_DOWN;
                else if (muted_q && gain_q != '0)                 state_d = S_RAMP_DOWN;
                else if (!muted_q && gain_q != GAIN_W'(256))      state_d = S_RAMP_UP;
            end
            S_RAMP_DOWN: begin
                if (gain_q == '0) begin
                    div_d   = '0;
                    state_d = (pend_q != PEND_NONE) ? S_RETUNE : S_IDLE;
                end else if (div_q == DIV_W'(RAMP_DIV - 1)) begin
                    div_d  = '0;
                    gain_d = gain_q - GAIN_W'(1);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_RETUNE: begin
                if (pend_q == PEND_UP) begin
                    freq_d = (freq_q + 32'(F_STEP) > 32'(F_MAX)) ? 32'(F_MIN) : freq_q + 32'(F_STEP);
                end else if (pend_q == PEND_DOWN) begin
                    freq_d = (freq_q < 32'(F_MIN) + 32'(F_STEP)) ? 32'(F_MAX) : freq_q - 32'(F_STEP);
                end
                pend_d   = PEND_NONE;
                settle_d = '0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    div_d    = '0;
                    state_d  = muted_q ? S_IDLE : S_RAMP_UP;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_RAMP_UP: begin
                if (muted_q) begin
                    div_d   = '0;
                    state_d = S_RAMP_DOWN;
                end else if (gain_q == GAIN_W'(256)) begin
                    state_d = S_IDLE;
                end else if (div_q == DIV_W'(RAMP_DIV - 1)) begin
                    div_d  = '0;
                    gain_d = gain_q + GAIN_W'(1);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A fresh request overrides whatever is queued, even one just consumed
        if (step_evt[0])      pend_d = PEND_UP;
        else if (step_evt[1]) pend_d = PEND_DOWN;
        tuning_d = (state_d != S_IDLE);
    end

    assign prod = pcm_in * $signed({1'b0, gain_q});

    always_ff @(posedge clk_25m or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pend_q   <= PEND_NONE;
            gain_q   <= GAIN_W'(256);
            div_q    <= '0;
            settle_q <= '0;
            freq_q   <= 32'(F_DEFAULT);
            muted_q  <= 1'b0;
            tuning_q <= 1'b0;
            pcm_q    <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            gain_q   <= gain_d;
            div_q    <= div_d;
            settle_q <= settle_d;
            freq_q   <= freq_d;
            muted_q  <= muted_d;
            tuning_q <= tuning_d;
            pcm_q    <= 16'(prod >>> 8);
        end
    end

    assign pcm_out = pcm_q;
    assign cw_freq = freq_q;
    assign tuning  = tuning_q;
    assign muted   = muted_q;

endmodule

// File: tb/tb_fm_tuner.sv
// Directed bench for fm_tuner with shortened timing parameters; expected values hand-computed.
module tb_fm_tuner;

    logic               clk_25m = 1'b0;
    logic               reset;
    logic               btn_up, btn_down, btn_center;
    logic signed [15:0] pcm_in;
    logic signed [15:0] pcm_out;
    logic        [31:0] cw_freq;
    logic               tuning, muted;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_25m = ~clk_25m;

    fm_tuner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (100),
        .REPEAT_PERIOD  (20),
        .RAMP_DIV       (1),
        .SETTLE_CYCLES  (8)
    ) dut (
        .clk_25m   (clk_25m),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_center(btn_center),
        .pcm_in    (pcm_in),
        .pcm_out   (pcm_out),
        .cw_freq   (cw_freq),
        .tuning    (tuning),
        .muted     (muted)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_tuning(input logic v, input int budget, input string tag);
        int n = 0;
        while (tuning !== v && n < budget) begin
            @(negedge clk_25m);
            n++;
        end
        chk(tag, 32'(tuning), 32'(v));
    endtask

    task automatic press(input int b, input string tag);
        btn_up     = (b == 0);
        btn_down   = (b == 1);
        btn_center = (b == 2);
        wait_tuning(1'b1, 40, {tag, "_rise"});
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        btn_center = 1'b0;
        wait_tuning(1'b0, 2000, {tag, "_fall"});
    endtask

    initial begin
        int n, changes, seen;
        logic [31:0] prev;

        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_center = 1'b0; pcm_in = 16'sd1000;
        repeat (3) @(negedge clk_25m);
        chk("rst_pcm", pcm_out, 0);
        chk("rst_freq", cw_freq, 108000000);
        chk("rst_tuning", 32'(tuning), 0);
        chk("rst_muted", 32'(muted), 0);

        reset = 1'b0;
        @(negedge clk_25m);
        chk("unity_gain", pcm_out, 1000);
        pcm_in = -16'sd3;
        @(negedge clk_25m);
        chk("unity_neg", pcm_out, -3);
        pcm_in = 16'sd1000;
        @(negedge clk_25m);

        // Glitch shorter than the debounce window
        btn_down = 1'b1;
        repeat (3) @(negedge clk_25m);
        btn_down = 1'b0;
        repeat (20) @(negedge clk_25m);
        chk("glitch_tuning", 32'(tuning), 0);
        chk("glitch_freq", cw_freq, 108000000);

        // Full down-step sequence with exact ramp timing
        btn_down = 1'b1;
        wait_tuning(1'b1, 40, "down_rise");
        btn_down = 1'b0;
        repeat (129) @(negedge clk_25m);
        chk("ramp_mid", pcm_out, 500);
        n = 129;
        while (cw_freq == 32'd108000000 && n < 400) begin
            @(negedge clk_25m);
            n++;
        end
        chk("retune_delay", n, 258);
        chk("down_freq", cw_freq, 107900000);
        chk("retune_silent", pcm_out, 0);
        repeat (8) @(negedge clk_25m);
        chk("settle_silent", pcm_out, 0);
        wait_tuning(1'b0, 400, "down_fall");
        chk("ramp_up_done", pcm_out, 1000);
        chk("down_freq_hold", cw_freq, 107900000);

        // Band edge wrap in both directions
        press(0, "up1");
        chk("up_to_max", cw_freq, 108000000);
        press(0, "up2");
        chk("wrap_up", cw_freq, 87500000);
        press(1, "dn1");
        chk("wrap_down", cw_freq, 108000000);
        press(0, "up3");
        chk("up_wrap_again", cw_freq, 87500000);

        // Autorepeat collapses into one pending step per sequence
        btn_up  = 1'b1;
        changes = 0;
        prev    = cw_freq;
        for (int i = 0; i < 1400; i++) begin
            @(negedge clk_25m);
            if (i == 300) btn_up = 1'b0;
            if (cw_freq != prev) begin
                changes++;
                chk("rpt_step_size", cw_freq - prev, 100000);
                prev = cw_freq;
            end
        end
        chk("rpt_changes", changes, 2);
        chk("rpt_freq", cw_freq, 87700000);
        chk("rpt_idle", 32'(tuning), 0);

        // Mute, step while muted, unmute
        press(2, "mute_on");
        chk("muted_set", 32'(muted), 1);
        chk("muted_pcm", pcm_out, 0);
        press(0, "mute_step");
        chk("mute_step_freq", cw_freq, 87800000);
        chk("mute_step_pcm", pcm_out, 0);
        chk("mute_step_muted", 32'(muted), 1);
        press(2, "mute_off");
        chk("unmuted", 32'(muted), 0);
        chk("unmuted_pcm", pcm_out, 1000);

        // Reset asserted during SETTLE
        btn_up = 1'b1;
        wait_tuning(1'b1, 40, "rst_seq_rise");
        btn_up = 1'b0;
        n = 0;
        while (cw_freq == 32'd87800000 && n < 400) begin
            @(negedge clk_25m);
            n++;
        end
        chk("pre_reset_step", cw_freq, 87900000);
        repeat (2) @(negedge clk_25m);
        reset = 1'b1;
        #1;
        chk("midrst_freq", cw_freq, 108000000);
        chk("midrst_tuning", 32'(tuning), 0);
        chk("midrst_pcm", pcm_out, 0);
        @(negedge clk_25m);
        reset = 1'b0;
        @(negedge clk_25m);
        chk("midrst_gain", pcm_out, 1000);
        repeat (600) @(negedge clk_25m);
        chk("post_rst_freq", cw_freq, 108000000);
        chk("post_rst_tuning", 32'(tuning), 0);

        // Up and down held together never step
        btn_up = 1'b1; btn_down = 1'b1;
        seen = 0;
        repeat (200) begin
            @(negedge clk_25m);
            if (tuning) seen = 1;
        end
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (20) begin
            @(negedge clk_25m);
            if (tuning) seen = 1;
        end
        chk("both_no_tune", seen, 0);
        chk("both_freq", cw_freq, 108000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fm_tuner.md
Name: fm_tuner

Overview:
- Front-panel controller for the FM transmitter: turns debounced buttons into carrier-frequency steps and a mute toggle.
- Drives the 32-bit carrier-frequency word into fmgen and gain-scales the PCM path from tonegen into fmgen.
- Every retune is sequenced click-free: ramp audio down, change frequency, settle, ramp audio up.

Parameters:
- F_MIN, 87500000, lowest carrier in Hz.
- F_MAX, 108000000, highest carrier in Hz.
- F_STEP, 100000, tuning step in Hz.
- F_DEFAULT, 108000000, carrier after reset; lies on the F_MIN + k*F_STEP grid.
- DEBOUNCE_CYCLES, 250000, consecutive equal samples needed to accept a button level (10 ms).
- REPEAT_DELAY, 12500000, hold time before autorepeat starts (500 ms).
- REPEAT_PERIOD, 2500000, autorepeat interval (100 ms).
- RAMP_DIV, 98, clocks per gain unit during a ramp.
- SETTLE_CYCLES, 25000, muted dwell after a retune (1 ms).

Ports:
- clk_25m  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- btn_up  in  1  raw button, step up.
- btn_down  in  1  raw button, step down.
- btn_center  in  1  raw button, mute toggle.
- pcm_in  in  16  signed audio from the tone generator.
- pcm_out  out  16  signed gain-scaled audio to fmgen.
- cw_freq  out  32  unsigned carrier frequency in Hz to fmgen.
- tuning  out  1  high whenever the FSM is not in IDLE.
- muted  out  1  user mute flag.

Behaviour:
- Reset values (asynchronous): cw_freq=F_DEFAULT, pcm_out=0, gain=256, tuning=0, muted=0, FSM=IDLE, debounced levels=0, pending=none.
- Input conditioning: each button passes a 2-FF synchroniser, then a per-button debounce counter. The stable level changes only after DEBOUNCE_CYCLES consecutive samples that differ from the current stable level.
- Press event: one-cycle pulse on each stable 0->1 edge.
- Autorepeat (up/down only): while held, an extra event fires REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles. Center never repeats.
- Both up and down stable-high: no up/down events are generated and the repeat timers are held cleared.
- Step request: an up or down event sets a single pending slot (up or down). Latest request wins; at most one step is queued.
- Center event: toggles muted in the same cycle, in any state.
- Gain and audio path:
  - gain is 9 bits, range 0..256.
  - pcm_out = (pcm_in * gain) >>> 8: signed 25-bit product, arithmetic shift, low 16 bits, registered.
  - Latency is 1 cycle. With gain=256 the output equals pcm_in exactly.
- FSM states:
  - IDLE:
    - pending set -> RAMP_DOWN.
    - else muted=1 and gain>0 -> RAMP_DOWN.
    - else muted=0 and gain<256 -> RAMP_UP.
  - RAMP_DOWN: gain decrements by 1 every RAMP_DIV cycles. At gain=0: pending set -> RETUNE, else -> IDLE.
  - RETUNE: single cycle. Consumes pending. Goes to SETTLE.
    - Up step: cw_freq = cw_freq+F_STEP; if that exceeds F_MAX, cw_freq = F_MIN (wrap).
    - Down step: cw_freq = cw_freq-F_STEP; if that is below F_MIN, cw_freq = F_MAX (wrap).
  - SETTLE: counts SETTLE_CYCLES with gain held at 0. Then: muted=1 -> IDLE (gain stays 0), else -> RAMP_UP.
  - RAMP_UP: gain increments by 1 every RAMP_DIV cycles. At gain=256 -> IDLE.
    - muted set mid-ramp -> RAMP_DOWN immediately from the current gain.
    - A pending request is serviced via the IDLE transition.
- cw_freq changes only in RETUNE, so fmgen never sees a frequency change while gain>0.
- Reset mid-operation: all state returns to reset values immediately; the pending request is lost; cw_freq returns to F_DEFAULT.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=100, REPEAT_PERIOD=20, RAMP_DIV=1, SETTLE_CYCLES=8.
- Reset, pcm_in=1000 constant -> cw_freq=108000000, tuning=0, muted=0, pcm_out=1000 one cycle after the synchroniser-free path; pcm_out=0 while reset is held.
- btn_down 3-cycle glitch -> no event, cw_freq unchanged. Then btn_down held 10 cycles -> tuning rises; pcm_out ramps 1000 down to 0 over 256 cycles; cw_freq=107900000 exactly once gain=0; 8 settle cycles; ramp back to 1000; tuning falls.
- At cw_freq=108000000, one btn_up press -> cw_freq=87500000 (wrap). Then btn_down -> cw_freq=108000000.
- btn_up held 300 cycles -> events at press, +100, +120, +140, ...; pending collapses repeats during each sequence; cw_freq increases by exactly F_STEP per completed RETUNE and never by more per sequence.
- btn_center press in IDLE -> muted=1, gain ramps to 0 and stays. btn_up while muted -> cw_freq steps, gain remains 0 after SETTLE. Second center press -> ramps to 256.
- Assert reset during SETTLE after a step -> cw_freq=108000000, gain=256, tuning=0 within the same cycle; no further retune after release. Also press up and down together -> no step.
